// File: rtl/booth_accum_pkg.sv
// Shared definitions for the Booth product accumulator.
//   state_e        : FSM state encoding (IDLE=0, ACCUM=1, DONE=2)
//   ACC_W_DEFAULT  : default signed accumulator width
//   LEN_W_DEFAULT  : default batch-length field width
//   PROD_W         : width of the incoming Booth product
package booth_accum_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int ACC_W_DEFAULT = 20;
  localparam int LEN_W_DEFAULT = 8;
  localparam int PROD_W        = 16;
endpackage

// File: rtl/booth_accum_sat_add.sv
// Combinational W-bit signed saturating adder.
//   a, b : signed W-bit operands
//   sum  : a+b clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf  : 1 when the clamp was applied
module sat_add #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W:0] wide;

  // One guard bit: the result fits iff the top two bits agree.
  assign wide = {a[W-1], a} + {b[W-1], b};
  assign ovf  = wide[W] ^ wide[W-1];

  always_comb begin
    sum = wide[W-1:0];
    if (ovf) sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/booth_accum.sv
// Batch accumulator for signed 16-bit Booth multiplier products.
//   CLK, RST   : clock, async active-low reset
//   in_valid/in_ready, product, len : product stream; len sampled on batch start
//   clear      : synchronous batch abort (highest priority)
//   out_valid/out_ready, acc_out, ovf : batch result handshake
module booth_accum
  import booth_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PROD_W-1:0]       product,
  input  logic [LEN_W-1:0]        len,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        acc_out,
  output logic                    ovf
);
  state_e             state;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   remaining;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic               sum_ovf;

  assign prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (sum_ovf)
  );

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign acc_out   = acc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc       <= prod_ext;
          // len=0 wraps to all-ones, i.e. a 2^LEN_W batch.
          remaining <= len - LEN_W'(1);
          ovf       <= 1'b0;
          state     <= (len == LEN_W'(1)) ? DONE : ACCUM;
        end
        ACCUM: if (in_valid) begin
          acc       <= sum;
          ovf       <= ovf | sum_ovf;
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_accum.sv
module tb_booth_accum;
  localparam int ACC_W = 20;
  localparam int LEN_W = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       product = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              clear = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  booth_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .len(len), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int acc_i();
    return int'($signed(acc_out));
  endfunction

  task automatic push(input int p, input int l);
    in_valid = 1'b1;
    product  = 16'(p);
    len      = LEN_W'(l);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_i(), 0);
    chk("rst_ovf", ovf, 0);
    step();
    RST = 1'b1;
    step();

    // 100 - 50 + 7
    push(100, 3);
    push(-50, 3);
    chk("b1_mid_valid", out_valid, 0);
    push(7, 3);
    chk("b1_valid", out_valid, 1);
    chk("b1_acc", acc_i(), 57);
    chk("b1_ovf", ovf, 0);
    chk("b1_ready", in_ready, 0);
    drain();
    chk("b1_drained", out_valid, 0);

    // single-product batch, result held while downstream stalls
    push(-16256, 1);
    chk("b2_valid", out_valid, 1);
    chk("b2_acc", acc_i(), -16256);
    in_valid = 1'b1;
    product  = 16'd1234;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b2_hold_acc", acc_i(), -16256);
      chk("b2_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("b2_hold_valid", out_valid, 1);
    drain();

    // positive saturation on the 32nd accept
    for (int i = 1; i <= 40; i++) begin
      push(16384, 40);
      if (i == 31) begin
        chk("b3_pre_sat_ovf", ovf, 0);
        chk("b3_pre_sat_acc", acc_i(), 507904);
      end
      if (i == 32) begin
        chk("b3_sat_ovf", ovf, 1);
        chk("b3_sat_acc", acc_i(), 524287);
      end
      if (i == 39) chk("b3_not_done", out_valid, 0);
    end
    chk("b3_valid", out_valid, 1);
    chk("b3_acc", acc_i(), 524287);
    chk("b3_ovf", ovf, 1);
    drain();

    // len=0 means 256 products; negative saturation
    for (int i = 1; i <= 256; i++) begin
      push(-16384, 0);
      if (i == 32) chk("b4_exact_min_ovf", ovf, 0);
      if (i == 255) chk("b4_not_done", out_valid, 0);
    end
    chk("b4_valid", out_valid, 1);
    chk("b4_acc", acc_i(), -524288);
    chk("b4_ovf", ovf, 1);
    drain();

    // clear mid-batch drops the in-flight product too
    push(10, 5);
    push(20, 5);
    in_valid = 1'b1;
    product  = 16'd99;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_acc", acc_i(), 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_ready", in_ready, 1);
    push(3, 2);
    push(4, 2);
    chk("b5_valid", out_valid, 1);
    chk("b5_acc", acc_i(), 7);
    chk("b5_ovf", ovf, 0);
    drain();

    // async reset between edges mid-batch
    push(1000, 5);
    push(2000, 5);
    #3;
    RST = 1'b0;
    #1;
    chk("arst_acc", acc_i(), 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_valid", out_valid, 0);
    #2;
    RST = 1'b1;
    step();
    push(5, 2);
    push(6, 2);
    chk("b6_valid", out_valid, 1);
    chk("b6_acc", acc_i(), 11);
    chk("b6_ovf", ovf, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_accum.md
BOOTH_ACCUM -- requirements
Module: booth_accum

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports are named CLK and RST.
REQ-002 Parameter ACC_W, default 20, SHALL set the signed accumulator width in bits.
REQ-003 Parameter LEN_W, default 8, SHALL set the width of the batch-length input.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  a product is presented on product.
REQ-007 in_ready  output  1  the block can accept a product this cycle.
REQ-008 product  input  16  signed two's-complement product from the upstream 8x8 Booth multiplier (final_result).
REQ-009 len  input  LEN_W  number of products per batch; sampled only on the first accept of a batch; 0 means 2^LEN_W.
REQ-010 clear  input  1  synchronous abort of the current batch.
REQ-011 out_valid  output  1  acc_out/ovf hold a completed batch result.
REQ-012 out_ready  input  1  the downstream stage takes the result.
REQ-013 acc_out  output  ACC_W  signed batch sum, registered.
REQ-014 ovf  output  1  sticky saturation flag for the batch, registered.

Function
REQ-015 An accept SHALL occur on a rising CLK edge when in_valid and in_ready are both 1.
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE and ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in DONE, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-018 An accept in IDLE SHALL load acc with sign-extended product, load remaining with len-1 (len=0 gives 2^LEN_W-1), and clear ovf.
REQ-019 After an accept in IDLE, the next state SHALL be DONE if the loaded remaining is 0, otherwise ACCUM.
REQ-020 An accept in ACCUM SHALL add sign-extended product to acc at ACC_W+1 bits and decrement remaining.
REQ-021 An accept in ACCUM that decrements remaining to 0 SHALL move the FSM to DONE.
REQ-022 If an ACC_W+1-bit sum does not fit in ACC_W signed bits, acc SHALL saturate to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and ovf SHALL be set.
REQ-023 ovf SHALL stay set until the next batch start, clear, or reset.
REQ-024 Once saturated, acc SHALL continue accumulating from the saturated value.
REQ-025 Result latency SHALL be 1 cycle: out_valid and the final acc_out SHALL be visible the cycle after the last accept.
REQ-026 In DONE, acc_out and ovf SHALL hold stable until out_ready=1.
REQ-027 In DONE, out_ready=1 SHALL return the FSM to IDLE on that edge; there is no input accept in the same cycle, since in_ready=0.
REQ-028 clear=1 SHALL force IDLE and zero acc, remaining and ovf from any state on that edge, with priority over accept and out_ready; any product presented that cycle is dropped.
REQ-029 in_valid=0 in ACCUM SHALL hold all state; the block SHALL NOT time out.
REQ-030 acc_out SHALL show the running sum during ACCUM; it is only meaningful when out_valid=1.

Reset
REQ-031 RST=0 SHALL asynchronously force IDLE, acc=0, remaining=0 and ovf=0, giving out_valid=0 and in_ready=1.
REQ-032 Release of RST SHALL take effect on the next CLK edge.
REQ-033 Reset mid-batch SHALL discard the partial sum.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (IDLE=0, ACCUM=1, DONE=2) and the default ACC_W and LEN_W values.
REQ-035 A single sub-module, sat_add, SHALL implement the combinational ACC_W-bit signed saturating add with its overflow output; all registers SHALL live in booth_accum.

Verification
REQ-036 len=3, products 100, -50, 7 on consecutive cycles -> out_valid on the 4th cycle with acc_out=57 and ovf=0.
REQ-037 len=1, product -16256 -> DONE after 1 cycle with acc_out=-16256; hold out_ready=0 for 5 cycles -> acc_out is stable and in_ready=0.
REQ-038 len=40, product 16384 every cycle -> 32nd accept saturates; final acc_out=524287 and ovf=1.
REQ-039 len=0, product -16384 x256 -> acc_out=-524288 and ovf=1, with out_valid after exactly 256 accepts.
REQ-040 clear asserted after 2 of 5 accepts, then a fresh len=2 batch of 3 and 4 -> acc_out=7 and ovf=0.
REQ-041 RST pulsed low mid-ACCUM, asynchronously to CLK -> outputs reset immediately; the next batch sums correctly.
